// File: rtl/aes_ctrl_pkg.sv
// Shared encodings for the AES round sequencer: round types, key lengths,
// round counts and controller states.
package aes_ctrl_pkg;

  typedef enum logic [1:0] {
    RT_INITIAL = 2'b00,
    RT_INTER   = 2'b01,
    RT_LAST    = 2'b10
  } round_type_e;

  localparam logic [1:0] KL_128  = 2'b00;
  localparam logic [1:0] KL_192  = 2'b01;
  localparam logic [1:0] KL_256  = 2'b10;
  localparam logic [1:0] KL_RSVD = 2'b11;

  localparam int unsigned NR_128 = 10;
  localparam int unsigned NR_192 = 12;
  localparam int unsigned NR_256 = 14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

  // Reserved key length maps to 0 so callers can reject it.
  function automatic int unsigned nr_of(input logic [1:0] kl);
    case (kl)
      KL_128:  return NR_128;
      KL_192:  return NR_192;
      KL_256:  return NR_256;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_counter.sv
// Round counter with latched Nr and key direction; decodes round type,
// round-key index and the last-round flag.
module aes_round_counter
  import aes_ctrl_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic             run_i,
  input  logic [CNT_W-1:0] nr_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] key_idx_o,
  output round_type_e      rt_o,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d, nr_q, nr_d;
  logic             dec_q, dec_d;

  assign last_o = (cnt_q == nr_q);

  always_comb begin
    cnt_d = cnt_q;
    nr_d  = nr_q;
    dec_d = dec_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = '0;
      nr_d  = nr_i;
      dec_d = dec_i;
    end else if (en_i && !last_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      nr_q  <= CNT_W'(NR_128);
      dec_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      nr_q  <= nr_d;
      dec_q <= dec_d;
    end
  end

  // cnt never exceeds nr_q, so the reverse index cannot underflow.
  assign key_idx_o = dec_q ? (nr_q - cnt_q) : cnt_q;
  assign cnt_o     = cnt_q;

  always_comb begin
    rt_o = RT_INITIAL;
    if (run_i && cnt_q != '0) rt_o = last_o ? RT_LAST : RT_INTER;
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: start handshake, Nr+1 round cycles, then a held
// result-valid until out_ready; abort returns to IDLE from any state.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int MAX_ROUNDS = 14,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [1:0]       key_len,
  input  logic             decrypt,
  input  logic             abort,
  output logic [1:0]       round_type,
  output logic [CNT_W-1:0] round_idx,
  output logic [CNT_W-1:0] key_idx,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err
);

  if (MAX_ROUNDS < int'(NR_256) || CNT_W < $clog2(MAX_ROUNDS + 1)) begin : g_bad_param
    $error("aes_round_ctrl: MAX_ROUNDS/CNT_W too small");
  end

  state_e      state_q;
  logic        busy_q, out_valid_q, err_q;
  logic        hs, rsvd, load, clr, run, last;
  round_type_e rt;

  // Abort masks ready so a coincident request is visibly refused.
  assign start_ready = (state_q == ST_IDLE) && !abort;
  assign hs          = start_valid && start_ready;
  assign rsvd        = (key_len == KL_RSVD);
  assign load        = hs && !rsvd;
  assign run         = (state_q == ST_RUN);
  assign clr         = abort || (state_q == ST_HOLD && out_ready);

  aes_round_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (clr),
    .load_i    (load),
    .en_i      (run),
    .run_i     (run),
    .nr_i      (CNT_W'(nr_of(key_len))),
    .dec_i     (decrypt),
    .cnt_o     (round_idx),
    .key_idx_o (key_idx),
    .rt_o      (rt),
    .last_o    (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= hs && rsvd;
      if (abort) begin
        state_q     <= ST_IDLE;
        busy_q      <= 1'b0;
        out_valid_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: if (load) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end
          ST_RUN: if (last) begin
            state_q     <= ST_HOLD;
            out_valid_q <= 1'b1;
          end
          ST_HOLD: if (out_ready) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
          end
          default: begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign round_type = rt;
  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign err        = err_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: expected per-round outputs are queued
// at each request and popped as the DUT steps through its rounds.
module tb_aes_round_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start_valid, start_ready, decrypt, abort;
  logic       busy, out_valid, out_ready, err;
  logic [1:0] key_len, round_type;
  logic [3:0] round_idx, key_idx;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] idx;
    logic [1:0] rt;
    logic [3:0] key;
  } exp_t;
  exp_t sb[$];

  aes_round_ctrl #(.MAX_ROUNDS(14), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .key_len     (key_len),
    .decrypt     (decrypt),
    .abort       (abort),
    .round_type  (round_type),
    .round_idx   (round_idx),
    .key_idx     (key_idx),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue the expected round sequence for one block.
  task automatic push_block(input int nr, input bit dec);
    exp_t e;
    for (int i = 0; i <= nr; i++) begin
      e.idx = 4'(i);
      e.rt  = (i == 0) ? 2'b00 : (i == nr) ? 2'b10 : 2'b01;
      e.key = dec ? 4'(nr - i) : 4'(i);
      sb.push_back(e);
    end
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_idx"},  32'(round_idx),  32'(e.idx));
      chk({tag, "_rt"},   32'(round_type), 32'(e.rt));
      chk({tag, "_key"},  32'(key_idx),    32'(e.key));
      chk({tag, "_busy"}, 32'(busy),       32'd1);
      chk({tag, "_ov"},   32'(out_valid),  32'd0);
    end
  endtask

  // Full block: request at cycle T (this negedge), rounds at T+1..T+1+nr,
  // out_valid from T+2+nr, held for 'hold' extra cycles before out_ready.
  task automatic run_block(input string tag, input logic [1:0] kl, input bit dec,
                           input int nr, input int hold);
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(start_ready), 32'd1);
    start_valid = 1'b1; key_len = kl; decrypt = dec; out_ready = 1'b1;
    push_block(nr, dec);
    @(negedge clk);
    start_valid = 1'b0; key_len = 2'b11; decrypt = ~dec;
    for (int i = 0; i <= nr; i++) begin
      pop_chk(tag);
      @(negedge clk);
    end
    chk({tag, "_ov"},     32'(out_valid),  32'd1);
    chk({tag, "_hidx"},   32'(round_idx),  32'(nr));
    chk({tag, "_hrt"},    32'(round_type), 32'd0);
    chk({tag, "_hkey"},   32'(key_idx),    dec ? 32'd0 : 32'(nr));
    out_ready = (hold == 0);
    for (int h = 1; h <= hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_ov"},  32'(out_valid), 32'd1);
      chk({tag, "_hold_idx"}, 32'(round_idx), 32'(nr));
      if (h == hold) out_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, "_end_ov"},   32'(out_valid),   32'd0);
    chk({tag, "_end_busy"}, 32'(busy),        32'd0);
    chk({tag, "_end_rdy"},  32'(start_ready), 32'd1);
    chk({tag, "_end_idx"},  32'(round_idx),   32'd0);
    key_len = 2'b00; decrypt = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start_valid = 1'b0; key_len = 2'b00; decrypt = 1'b0;
    abort = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_busy", 32'(busy),        32'd0);
    chk("rst_ov",   32'(out_valid),   32'd0);
    chk("rst_err",  32'(err),         32'd0);
    chk("rst_rt",   32'(round_type),  32'd0);
    chk("rst_idx",  32'(round_idx),   32'd0);
    chk("rst_key",  32'(key_idx),     32'd0);
    chk("rst_rdy",  32'(start_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;

    run_block("aes128", 2'b00, 1'b0, 10, 0);
    run_block("aes256d", 2'b10, 1'b1, 14, 0);
    run_block("aes192h", 2'b01, 1'b0, 12, 5);

    // Reserved key length: one-cycle err, nothing starts.
    @(negedge clk);
    start_valid = 1'b1; key_len = 2'b11;
    @(negedge clk);
    start_valid = 1'b0; key_len = 2'b00;
    chk("rsvd_err",  32'(err),         32'd1);
    chk("rsvd_busy", 32'(busy),        32'd0);
    chk("rsvd_rdy",  32'(start_ready), 32'd1);
    @(negedge clk);
    chk("rsvd_err_clr", 32'(err),  32'd0);
    chk("rsvd_busy2",   32'(busy), 32'd0);

    // Abort at round 4.
    start_valid = 1'b1; key_len = 2'b00; decrypt = 1'b0;
    push_block(10, 1'b0);
    @(negedge clk);
    start_valid = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      pop_chk("abort_run");
      if (i == 4) abort = 1'b1;
      else @(negedge clk);
    end
    sb.delete();
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy),      32'd0);
    chk("abort_idx",  32'(round_idx), 32'd0);
    chk("abort_ov",   32'(out_valid), 32'd0);
    chk("abort_err",  32'(err),       32'd0);
    // Abort in IDLE refuses a coincident request.
    abort = 1'b1; start_valid = 1'b1;
    #1;
    chk("abort_idle_rdy", 32'(start_ready), 32'd0);
    @(negedge clk);
    abort = 1'b0; start_valid = 1'b0;
    chk("abort_idle_busy", 32'(busy), 32'd0);
    chk("abort_idle_err",  32'(err),  32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_ov", 32'(out_valid), 32'd0);
    end
    run_block("post_abort", 2'b00, 1'b0, 10, 0);

    // Asynchronous reset mid-run, off the clock edge.
    @(negedge clk);
    start_valid = 1'b1; key_len = 2'b10; decrypt = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0; start_valid = 1'b1;
    #1;
    chk("arst_busy", 32'(busy),        32'd0);
    chk("arst_idx",  32'(round_idx),   32'd0);
    chk("arst_key",  32'(key_idx),     32'd0);
    chk("arst_rt",   32'(round_type),  32'd0);
    chk("arst_ov",   32'(out_valid),   32'd0);
    chk("arst_err",  32'(err),         32'd0);
    chk("arst_rdy",  32'(start_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("arst_ignore_busy", 32'(busy),      32'd0);
    chk("arst_ignore_idx",  32'(round_idx), 32'd0);
    start_valid = 1'b0; rst_n = 1'b1;
    run_block("post_rst", 2'b00, 1'b0, 10, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
